powlib_ipsaxi_wrx: RTL and testbench
====================================

# powlib_ipsaxi_wrx

Parametrised AXI4 write-slave front end that converts AXI write bursts (AW/W/B) into a stream of single-beat PLB write requests (addr/data/be). Generalises the existing single-mode write slave: per-beat address generation for FIXED, INCR and WRAP bursts, transfer-size legality checking, WLAST protocol checking with correct OKAY/SLVERR responses, and self-contained 2-entry output and response buffers. Sits between an AXI interconnect port and the PLB write side of a powlib IP.

## Interface
- IDW, 1, AXI ID width
- B_BPD, 4, bytes per data beat; power of two, 1..128
- B_AW, 32, address width (independent of data width)
- Derived: B_DW = 8*B_BPD, B_BEW = B_BPD, MAXSZ = log2(B_BPD)

- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- awid  in  IDW  write ID
- awaddr  in  B_AW  burst start address
- awlen  in  8  beats minus one
- awsize  in  3  log2 bytes per beat
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- awvalid / awready  in / out  1  AW handshake
- wdata / wstrb / wlast  in  B_DW / B_BEW / 1  write beat
- wvalid / wready  in / out  1  W handshake
- bid / bresp  out  IDW / 2  response; 00 OKAY, 10 SLVERR
- bvalid / bready  out / in  1  B handshake
- rdaddr / rddata / rdbe  out  B_AW / B_DW / B_BEW  PLB write beat
- rdvld / rdrdy  out / in  1  PLB handshake

## Operation
- FSM states IDLE, DATA. Reset -> IDLE.
- IDLE: awready = 1 iff response buffer holds <2 entries. On AW handshake latch id/addr/len/size/burst, clear beat counter, compute err_hdr, go DATA.
- err_hdr set if awsize > MAXSZ, awburst == 11, or WRAP with awlen not in {1,3,7,15}.
- DATA: wready = 1 if err_hdr, else iff output buffer holds <2 entries. Each W handshake: if !err_hdr push {addr, wdata, wstrb} to output buffer; advance address and counter.
- Burst ends on the beat where counter == len OR wlast == 1, whichever first. Protocol error (err_wl) if wlast != (counter == len) on any accepted beat. Early wlast: burst terminates at that beat. Missing wlast on final beat: burst terminates at counter == len; following W beats belong to the next burst.
- At burst end push {id, (err_hdr|err_wl) ? 10 : 00} to response buffer, go IDLE.
- err_hdr bursts: all beats accepted and dropped, no rdvld, SLVERR returned.
- Address (bytes = 1<<size, arithmetic modulo 2^B_AW): FIXED: unchanged. INCR: next = (addr & ~(bytes-1)) + bytes; first beat uses awaddr unmodified. WRAP: wb = (len+1)*bytes; next = (addr & ~(wb-1)) | ((addr+bytes) & (wb-1)).
- wstrb passed unmodified to rdbe; no lane masking.
- Output and response buffers: 2-entry FIFOs, simultaneous push/pop at count 2 not permitted by construction (push gated by count<2); push/pop same cycle at count 1 keeps count 1.

## Timing
- Reset values: awready 0, wready 0, bvalid 0, rdvld 0, bid/bresp/rdaddr/rddata/rdbe 0. awready rises in first cycle after rst deasserts.
- AW handshake in cycle N -> wready may assert in N+1 (one-cycle bubble between bursts; awready 0 throughout DATA).
- W handshake in cycle M -> rdvld with that beat in M+1 (when buffer empty or ahead entries drained).
- Final beat in M -> bvalid in M+1; awready in M+1 if response buffer not full.
- Sustained throughput 1 beat/cycle with rdrdy held 1.
- rdvld/bvalid, once asserted, hold with stable payload until accepted.
- Reset mid-burst: all state, buffers and pending responses discarded immediately; no partial response emitted.

## Configuration
- POWLIB_IPSAXI_WRAP_EN defined: WRAP bursts supported as above.
- Undefined: wrap address logic omitted; awburst == 10 sets err_hdr (beats dropped, SLVERR).

## Test plan
- INCR, awaddr 0x100, len 3, size 2, B_BPD 4 -> rdaddr 0x100,0x104,0x108,0x10C, back-to-back rdvld, bresp 00, bid = awid.
- WRAP (macro on), awaddr 0x108, len 3, size 2 -> rdaddr 0x108,0x10C,0x100,0x104, bresp 00; macro off -> no rdvld, bresp 10.
- FIXED, awaddr 0x40, len 2 -> three beats at 0x40, distinct rddata preserved in order; unaligned INCR 0x102 size 2 -> 0x102,0x104.
- awsize 3 with B_BPD 4, len 1 -> two beats accepted, zero rdvld, bresp 10; next OKAY burst proceeds normally.
- len 3 with wlast on beat 1 -> two PLB beats, bresp 10, next AW accepted the cycle after response push.
- rdrdy held 0 -> wready drops after 2 beats; bready 0 for 2 bursts -> awready 0; assert rst mid-burst -> all valids 0 same cycle, no B emitted.

Source files
------------

// File: rtl/powlib_ipsaxi_wrx_if.sv
// AXI4 write-channel (AW/W/B) plus PLB write-beat bundle for powlib_ipsaxi_wrx.
// The slave modport is the front end's view; the master modport is the upstream/downstream view.
interface powlib_ipsaxi_wrx_if #(
  parameter int unsigned IDW   = 1,
  parameter int unsigned B_BPD = 4,
  parameter int unsigned B_AW  = 32
) ();
  localparam int unsigned B_DW = 8 * B_BPD;

  // AXI write address channel
  logic [IDW-1:0]   awid;
  logic [B_AW-1:0]  awaddr;
  logic [7:0]       awlen;
  logic [2:0]       awsize;
  logic [1:0]       awburst;
  logic             awvalid;
  logic             awready;
  // AXI write data channel
  logic [B_DW-1:0]  wdata;
  logic [B_BPD-1:0] wstrb;
  logic             wlast;
  logic             wvalid;
  logic             wready;
  // AXI write response channel
  logic [IDW-1:0]   bid;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;
  // PLB single-beat write stream
  logic [B_AW-1:0]  rdaddr;
  logic [B_DW-1:0]  rddata;
  logic [B_BPD-1:0] rdbe;
  logic             rdvld;
  logic             rdrdy;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    output rdaddr, rddata, rdbe, rdvld,
    input  rdrdy
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    input  rdaddr, rddata, rdbe, rdvld,
    output rdrdy
  );
endinterface

// File: rtl/powlib_ipsaxi_wrx.sv
// AXI4 write slave front end: splits AW/W bursts into single-beat PLB writes with
// FIXED/INCR(/WRAP) address generation, size/burst/WLAST checking and a 2-entry
// output buffer plus a 2-entry response buffer.
// Optional feature macro: POWLIB_IPSAXI_WRAP_EN enables WRAP bursts; without it WRAP
// bursts are treated as header errors (beats dropped, SLVERR).
module powlib_ipsaxi_wrx #(
  parameter int unsigned IDW   = 1,
  parameter int unsigned B_BPD = 4,
  parameter int unsigned B_AW  = 32
) (
  input logic                clk,
  input logic                rst,
  powlib_ipsaxi_wrx_if.slave bus
);
  localparam int unsigned B_DW  = 8 * B_BPD;
  localparam int unsigned MAXSZ = $clog2(B_BPD);
  localparam int unsigned OW    = B_AW + B_DW + B_BPD;
  localparam int unsigned RW    = IDW + 2;
  localparam logic [B_AW-1:0] AddrOne = B_AW'(1);

  typedef enum logic [0:0] {StIdle, StData} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [B_AW-1:0]  addr_q, addr_d;
  logic [7:0]       len_q, len_d;
  logic [2:0]       size_q, size_d;
  logic [1:0]       burst_q, burst_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_hdr_q, err_hdr_d;
  logic             err_wl_q, err_wl_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;

  // Buffers: entry 0 is the head presented on the outputs.
  logic [OW-1:0]    out_e0_q, out_e1_q;
  logic [1:0]       out_cnt_q, out_cnt_d;
  logic [RW-1:0]    rsp_e0_q, rsp_e1_q;
  logic [1:0]       rsp_cnt_q, rsp_cnt_d;

  logic             aw_hs, w_hs;
  logic             out_push, out_pop, rsp_push, rsp_pop;
  logic [OW-1:0]    out_new;
  logic [RW-1:0]    rsp_new;
  logic             hdr_err;
  logic             beat_last, wl_bad;
  logic [B_AW-1:0]  bytes, incr_addr, next_addr;
`ifdef POWLIB_IPSAXI_WRAP_EN
  logic [B_AW-1:0]  wrap_bytes, wrap_addr;
`endif

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.rdvld   = (out_cnt_q != 2'd0);
  assign bus.bvalid  = (rsp_cnt_q != 2'd0);
  assign {bus.rdaddr, bus.rddata, bus.rdbe} = out_e0_q;
  assign {bus.bid, bus.bresp}               = rsp_e0_q;

  // Header legality of the incoming AW request.
  always_comb begin
    hdr_err = (bus.awsize > 3'(MAXSZ)) | (bus.awburst == 2'b11);
`ifdef POWLIB_IPSAXI_WRAP_EN
    if (bus.awburst == 2'b10) begin
      hdr_err = hdr_err | ~((bus.awlen == 8'd1) | (bus.awlen == 8'd3) |
                            (bus.awlen == 8'd7) | (bus.awlen == 8'd15));
    end
`else
    hdr_err = hdr_err | (bus.awburst == 2'b10);
`endif
  end

  // Address of the beat following the current one.
  always_comb begin
    bytes     = AddrOne << size_q;
    incr_addr = (addr_q & ~(bytes - AddrOne)) + bytes;
`ifdef POWLIB_IPSAXI_WRAP_EN
    wrap_bytes = (B_AW'(len_q) + AddrOne) * bytes;
    wrap_addr  = (addr_q & ~(wrap_bytes - AddrOne)) |
                 ((addr_q + bytes) & (wrap_bytes - AddrOne));
`endif
    case (burst_q)
      2'b01:   next_addr = incr_addr;
`ifdef POWLIB_IPSAXI_WRAP_EN
      2'b10:   next_addr = wrap_addr;
`endif
      default: next_addr = addr_q;
    endcase
  end

  // Burst FSM next state, buffer push/pop and next-cycle ready flags.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_hdr_d = err_hdr_q;
    err_wl_d  = err_wl_q;
    out_push  = 1'b0;
    rsp_push  = 1'b0;
    aw_hs     = bus.awvalid & awready_q;
    w_hs      = bus.wvalid & wready_q;
    out_pop   = bus.rdvld & bus.rdrdy;
    rsp_pop   = bus.bvalid & bus.bready;
    beat_last = (cnt_q == len_q);
    wl_bad    = bus.wlast ^ beat_last;
    out_new   = {addr_q, bus.wdata, bus.wstrb};
    rsp_new   = {id_q, ((err_hdr_q | err_wl_q | wl_bad) ? 2'b10 : 2'b00)};

    unique case (state_q)
      StIdle: begin
        if (aw_hs) begin
          id_d      = bus.awid;
          addr_d    = bus.awaddr;
          len_d     = bus.awlen;
          size_d    = bus.awsize;
          burst_d   = bus.awburst;
          cnt_d     = 8'd0;
          err_hdr_d = hdr_err;
          err_wl_d  = 1'b0;
          state_d   = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          out_push = ~err_hdr_q;
          addr_d   = next_addr;
          cnt_d    = cnt_q + 8'd1;
          err_wl_d = err_wl_q | wl_bad;
          // A short (early WLAST) or long (missing WLAST) burst still ends here.
          if (beat_last | bus.wlast) begin
            rsp_push = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    out_cnt_d = out_cnt_q + {1'b0, out_push} - {1'b0, out_pop};
    rsp_cnt_d = rsp_cnt_q + {1'b0, rsp_push} - {1'b0, rsp_pop};
    awready_d = (state_d == StIdle) & (rsp_cnt_d != 2'd2);
    wready_d  = (state_d == StData) & (err_hdr_d | (out_cnt_d != 2'd2));
  end

  // State, registered handshake outputs and buffer storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_hdr_q <= 1'b0;
      err_wl_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      out_e0_q  <= '0;
      out_e1_q  <= '0;
      out_cnt_q <= '0;
      rsp_e0_q  <= '0;
      rsp_e1_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_hdr_q <= err_hdr_d;
      err_wl_q  <= err_wl_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      out_cnt_q <= out_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      // Push is never offered at count 2, so pop+push only happens at count 1.
      if (out_pop) begin
        out_e0_q <= (out_push && out_cnt_q == 2'd1) ? out_new : out_e1_q;
      end else if (out_push) begin
        if (out_cnt_q == 2'd0) out_e0_q <= out_new;
        else                   out_e1_q <= out_new;
      end
      if (rsp_pop) begin
        rsp_e0_q <= (rsp_push && rsp_cnt_q == 2'd1) ? rsp_new : rsp_e1_q;
      end else if (rsp_push) begin
        if (rsp_cnt_q == 2'd0) rsp_e0_q <= rsp_new;
        else                   rsp_e1_q <= rsp_new;
      end
    end
  end
endmodule

// File: tb/tb_powlib_ipsaxi_wrx.sv
// Scoreboard bench for powlib_ipsaxi_wrx: directed bursts from the test plan followed by
// randomized bursts; expectations come from a closed-form burst model.
module tb_powlib_ipsaxi_wrx;
  localparam int unsigned IDW   = 4;
  localparam int unsigned B_BPD = 4;
  localparam int unsigned B_AW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  powlib_ipsaxi_wrx_if #(.IDW(IDW), .B_BPD(B_BPD), .B_AW(B_AW)) bus ();

  powlib_ipsaxi_wrx #(.IDW(IDW), .B_BPD(B_BPD), .B_AW(B_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } rsp_t;

  beat_t exp_beats[$];
  rsp_t  exp_rsp[$];
  int    checks = 0;
  int    fails = 0;
  int    rd_mode = 1;  // 0 random, 1 held high, 2 held low
  int    b_mode = 1;
  int    rst_epoch = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  function automatic bit model_hdr(input int size, input int burst, input int len);
    bit wrap_ok;
`ifdef POWLIB_IPSAXI_WRAP_EN
    wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
`else
    wrap_ok = 1'b0;
`endif
    return (size > 2) || (burst == 3) || (burst == 2 && !wrap_ok);
  endfunction

  // Address of beat i computed directly from the burst start.
  function automatic logic [31:0] model_addr(input logic [31:0] start, input int size,
                                             input int burst, input int len, input int i);
    longint unsigned bytes, wb, s, base;
    bytes = 64'd1 << size;
    s = 64'(start);
    case (burst)
      1: begin
        if (i == 0) return start;
        return 32'(s - (s % bytes) + 64'(i) * bytes);
      end
      2: begin
        wb = 64'(len + 1) * bytes;
        base = s - (s % wb);
        return 32'(base + ((s - base + 64'(i) * bytes) % wb));
      end
      default: return start;
    endcase
  endfunction

  // Ready generators for the two output channels.
  initial begin
    bus.rdrdy = 1'b1;
    bus.bready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rdrdy  = (rd_mode == 1) ? 1'b1 : (rd_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.bready = (b_mode == 1) ? 1'b1 : (b_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks hold stability.
  logic        plb_hold = 1'b0, b_hold = 1'b0;
  logic [67:0] plb_prev = '0;
  logic [5:0]  b_prev = '0;
  int          mon_epoch = 0;
  always @(negedge clk) begin
    beat_t eb;
    rsp_t  er;
    if (mon_epoch != rst_epoch || !rst) begin
      plb_hold = 1'b0;
      b_hold = 1'b0;
      mon_epoch = rst_epoch;
    end
    if (rst) begin
      if (plb_hold) check("plb_stable", {bus.rdvld, bus.rdaddr, bus.rddata, bus.rdbe},
                          {1'b1, plb_prev});
      if (b_hold) check("b_stable", {bus.bvalid, bus.bid, bus.bresp}, {1'b1, b_prev});
      if (bus.rdvld && bus.rdrdy) begin
        if (exp_beats.size() == 0) timeout_fail("plb_unexpected_beat");
        else begin
          eb = exp_beats.pop_front();
          check("plb_beat", {bus.rdaddr, bus.rddata, bus.rdbe}, eb);
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (exp_rsp.size() == 0) timeout_fail("b_unexpected_resp");
        else begin
          er = exp_rsp.pop_front();
          check("b_resp", {bus.bid, bus.bresp}, er);
        end
      end
      plb_hold = bus.rdvld && !bus.rdrdy;
      plb_prev = {bus.rdaddr, bus.rddata, bus.rdbe};
      b_hold = bus.bvalid && !bus.bready;
      b_prev = {bus.bid, bus.bresp};
    end
  end

  // Drive AW and wait for its handshake; returns 0 on timeout.
  task automatic drive_aw(input logic [3:0] id, input logic [31:0] start, input int len,
                          input int size, input int burst, output bit ok);
    int n = 0;
    ok = 1'b1;
    bus.awid = id;
    bus.awaddr = start;
    bus.awlen = 8'(len);
    bus.awsize = 3'(size);
    bus.awburst = 2'(burst);
    bus.awvalid = 1'b1;
    @(negedge clk);
    while (!bus.awready) begin
      if (++n > 500) begin
        timeout_fail("aw_handshake");
        bus.awvalid = 1'b0;
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
  endtask

  // wl_mode: 0 normal WLAST, 1 early WLAST on beat k, 2 WLAST never asserted.
  task automatic send_burst(input logic [3:0] id, input logic [31:0] start, input int len,
                            input int size, input int burst, input int wl_mode, input int k,
                            input bit gaps, input bit chk);
    bit hdr, ok;
    int nb, n;
    logic [31:0] data[$];
    logic [3:0] strb[$];
    beat_t b;
    rsp_t r;
    hdr = model_hdr(size, burst, len);
    nb = (wl_mode == 1) ? k + 1 : len + 1;
    for (int i = 0; i < nb; i++) begin
      data.push_back($urandom);
      strb.push_back(4'($urandom_range(0, 15)));
      if (!hdr) begin
        b.addr = model_addr(start, size, burst, len, i);
        b.data = data[i];
        b.be = strb[i];
        exp_beats.push_back(b);
      end
    end
    r.id = id;
    r.resp = (hdr || wl_mode != 0) ? 2'b10 : 2'b00;
    exp_rsp.push_back(r);

    drive_aw(id, start, len, size, burst, ok);
    if (!ok) return;
    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.wvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.wvalid = 1'b1;
      bus.wdata = data[i];
      bus.wstrb = strb[i];
      bus.wlast = (wl_mode == 0 && i == len) || (wl_mode == 1 && i == k);
      @(negedge clk);
      if (chk) begin
        check("wready_beat", bus.wready, 1'b1);
        if (!hdr && i > 0) check("rdvld_back_to_back", bus.rdvld, 1'b1);
      end
      n = 0;
      while (!bus.wready) begin
        if (++n > 500) begin
          timeout_fail("w_handshake");
          bus.wvalid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      @(posedge clk);
      #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    if (chk) begin
      @(negedge clk);
      check("bvalid_after_last", bus.bvalid, 1'b1);
      check("awready_after_last", bus.awready, 1'b1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_rsp.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, {exp_beats.size(), exp_rsp.size()}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int acc;
    bus.awvalid = 1'b0;
    bus.awid = '0;
    bus.awaddr = '0;
    bus.awlen = '0;
    bus.awsize = '0;
    bus.awburst = '0;
    bus.wvalid = 1'b0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.wlast = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valids", {bus.awready, bus.wready, bus.bvalid, bus.rdvld}, 4'b0000);
    check("reset_payload", {bus.bid, bus.bresp, bus.rdaddr, bus.rddata, bus.rdbe}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("awready_after_reset", bus.awready, 1'b1);
    @(posedge clk);
    #1;

    // Directed bursts from the test plan.
    send_burst(4'd5, 32'h100, 3, 2, 1, 0, 0, 1'b0, 1'b1);
    send_burst(4'd2, 32'h108, 3, 2, 2, 0, 0, 1'b0, 1'b1);
    send_burst(4'd7, 32'h40, 2, 2, 0, 0, 0, 1'b0, 1'b1);
    send_burst(4'd1, 32'h102, 1, 2, 1, 0, 0, 1'b0, 1'b1);
    send_burst(4'd3, 32'h200, 1, 3, 1, 0, 0, 1'b0, 1'b1);
    send_burst(4'd6, 32'h300, 3, 2, 1, 0, 0, 1'b0, 1'b1);
    send_burst(4'd9, 32'h400, 3, 2, 1, 1, 1, 1'b0, 1'b1);
    send_burst(4'd10, 32'h500, 2, 2, 1, 2, 0, 1'b0, 1'b1);
    drain("drain_directed");

    // Response buffer full: two unacknowledged bursts block further AW.
    b_mode = 2;
    send_burst(4'd11, 32'h600, 1, 2, 1, 0, 0, 1'b0, 1'b0);
    send_burst(4'd12, 32'h700, 0, 2, 1, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("awready_rsp_full", {bus.awready, bus.bvalid}, 2'b01);
    b_mode = 1;
    drain("drain_rsp_full");

    // Output stall, then reset in the middle of the burst.
    rd_mode = 2;
    @(posedge clk);
    #1;
    drive_aw(4'd13, 32'h800, 7, 2, 1, ok);
    bus.wvalid = 1'b1;
    bus.wlast = 1'b0;
    bus.wdata = 32'hdead_beef;
    bus.wstrb = 4'hf;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.wvalid && bus.wready) acc++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("stall_beats_accepted", acc, 2);
    check("stall_wready_low", {bus.wready, bus.rdvld}, 2'b01);
    #2;
    rst = 1'b0;
    rst_epoch++;
    #1;
    check("midreset_valids", {bus.awready, bus.wready, bus.bvalid, bus.rdvld}, 4'b0000);
    bus.wvalid = 1'b0;
    rd_mode = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("awready_after_midreset", {bus.awready, bus.bvalid, bus.rdvld}, 3'b100);
    @(posedge clk);
    #1;
    send_burst(4'd14, 32'h900, 3, 2, 1, 0, 0, 1'b0, 1'b1);
    drain("drain_after_reset");

    // Randomized bursts with random backpressure on both output channels.
    rd_mode = 0;
    b_mode = 0;
    for (int t = 0; t < 40; t++) begin
      int size, burst, len, wl, k, r;
      size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      burst = (r < 4) ? 1 : (r < 6) ? 0 : (r < 9) ? 2 : 3;
      if (burst == 2) begin
        r = $urandom_range(0, 4);
        len = (r == 0) ? 1 : (r == 1) ? 3 : (r == 2) ? 7 : (r == 3) ? 15 : 2;
      end else begin
        len = $urandom_range(0, 7);
      end
      r = $urandom_range(0, 9);
      wl = 0;
      k = 0;
      if (r == 0 && len > 0) begin
        wl = 1;
        k = $urandom_range(0, len - 1);
      end else if (r == 1) begin
        wl = 2;
      end
      send_burst(4'($urandom_range(0, 15)), $urandom, len, size, burst, wl, k, 1'b1, 1'b0);
    end
    rd_mode = 1;
    b_mode = 1;
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
